// File: rtl/nibble_frame_rx.sv
// Serial frame receiver: recovers start / 4 data / optional parity / stop frames
// from an LSB-first bit stream and presents good words on a valid/ready port.
module nibble_frame_rx #(
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       en,
  input  logic       sin,
  output logic [3:0] Q,
  output logic       valid,
  input  logic       ready,
  output logic       perr,
  output logic       ferr,
  output logic       ovr
);

  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

  state_t     state, state_nxt;
  logic [3:0] sh, sh_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic       pbad, pbad_nxt;
  logic [3:0] q_nxt;
  logic       valid_nxt, perr_nxt, ferr_nxt, ovr_nxt;
  logic       good, load;

  function automatic logic parity_bad(input logic [3:0] data, input logic pbit);
    return (^data ^ pbit) != PARITY_ODD;
  endfunction

  always_comb begin
    state_nxt = state;
    sh_nxt    = sh;
    cnt_nxt   = cnt;
    pbad_nxt  = pbad;
    perr_nxt  = 1'b0;
    ferr_nxt  = 1'b0;
    good      = 1'b0;
    if (en) begin
      case (state)
        IDLE: begin
          if (!sin) begin
            state_nxt = DATA;
            cnt_nxt   = 2'd0;
          end
        end
        DATA: begin
          sh_nxt  = {sin, sh[3:1]};
          cnt_nxt = cnt + 2'd1;
          if (cnt == 2'd3) state_nxt = PARITY_EN ? PAR : STOP;
        end
        PAR: begin
          pbad_nxt  = parity_bad(sh, sin);
          state_nxt = STOP;
        end
        STOP: begin
          state_nxt = IDLE;
          // A bad stop bit outranks a parity mismatch.
          if (!sin)      ferr_nxt = 1'b1;
          else if (pbad) perr_nxt = 1'b1;
          else           good     = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end

    // A good word may land in the same edge the held word is accepted.
    load      = good && (!valid || ready);
    ovr_nxt   = good && valid && !ready;
    q_nxt     = load ? sh : Q;
    valid_nxt = valid;
    if (load)                valid_nxt = 1'b1;
    else if (valid && ready) valid_nxt = 1'b0;
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state <= IDLE;
      sh    <= 4'd0;
      cnt   <= 2'd0;
      pbad  <= 1'b0;
      Q     <= 4'd0;
      valid <= 1'b0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      state <= state_nxt;
      sh    <= sh_nxt;
      cnt   <= cnt_nxt;
      pbad  <= pbad_nxt;
      Q     <= q_nxt;
      valid <= valid_nxt;
      perr  <= perr_nxt;
      ferr  <= ferr_nxt;
      ovr   <= ovr_nxt;
    end
  end

endmodule
